par8_tx_arbiter: RTL and testbench

- Shares the single par8_transmitter byte port between two message sources, e.g. the command-response path and the status/result path.
- Grants whole messages, never interleaved bytes. Arbitration is round-robin.
- Feeds bytes to the transmitter through its ready_next/valid pulse handshake and enforces a hold-off after each byte.
- Aborts a message whose source stalls mid-message.

---
 rtl/par8_tx_arbiter_pkg.sv | 15 +
 rtl/par8_tx_arbiter_if.sv | 35 +++
 rtl/par8_tx_arbiter_rr_arb2.sv | 24 ++
 rtl/par8_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_par8_tx_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/par8_tx_arbiter_pkg.sv
// Shared definitions for the par8 transmitter arbiter.
//   state_t   : arbiter FSM states (IDLE, SEND, HOLD)
//   REQ0/REQ1 : requester indices into grant / pick vectors
package par8_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_HOLD
  } state_t;

  localparam int unsigned REQ0 = 0;
  localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/par8_tx_arbiter_if.sv
// Bundle of source, transmitter and status signals around par8_tx_arbiter.
//   master : the environment (two byte sources, transmitter ready, observers)
//   slave  : the arbiter itself
interface par8_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;
  logic       ready_next;
  logic [7:0] txd_data;
  logic       valid;
  logic [1:0] grant;
  logic       busy;
  logic       abort;

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output ready_next,
    input  req0_ready, req1_ready,
    input  txd_data, valid, grant, busy, abort
  );

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  ready_next,
    output req0_ready, req1_ready,
    output txd_data, valid, grant, busy, abort
  );
endinterface

// File: rtl/par8_tx_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   req[1:0]   : requesting sources
//   last_grant : index of the most recently granted source
//   pick[1:0]  : one-hot winner, 0 when nobody requests
module rr_arb2
  import par8_tx_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // Contention: favour whichever source did not win last time.
      2'b11:   pick = (last_grant == 1'(REQ1)) ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/par8_tx_arbiter.sv
// par8_tx_arbiter: shares the par8_transmitter byte port between two message
// sources. Whole messages are granted round-robin, bytes are issued as
// one-cycle valid pulses with a hold-off after each, and a source that stalls
// mid-message for TIMEOUT cycles has its message aborted.
//   clk, reset : 100 MHz clock, synchronous active-high reset
//   bus        : source handshakes, transmitter byte port, grant/busy/abort
module par8_tx_arbiter
  import par8_tx_arbiter_pkg::*;
#(
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input logic            clk,
  input logic            reset,
  par8_tx_arbiter_if.slave bus
);

  localparam logic [3:0]      HOLD_LAST = 4'(HOLDOFF - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [3:0]      hold_q, hold_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            end_q, end_d;
  logic [7:0]      txd_q, txd_d;
  logic            valid_q, valid_d;
  logic            abort_q, abort_d;

  logic [1:0]      pick;
  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            xfer;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .pick       (pick)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_last  = 1'b0;
    if (grant_q[REQ0]) begin
      sel_valid = bus.req0_valid;
      sel_data  = bus.req0_data;
      sel_last  = bus.req0_last;
    end else if (grant_q[REQ1]) begin
      sel_valid = bus.req1_valid;
      sel_data  = bus.req1_data;
      sel_last  = bus.req1_last;
    end
  end

  assign xfer = (state_q == ST_SEND) && bus.ready_next && sel_valid;

  assign bus.req0_ready = grant_q[REQ0] && (state_q == ST_SEND) && bus.ready_next && bus.req0_valid;
  assign bus.req1_ready = grant_q[REQ1] && (state_q == ST_SEND) && bus.ready_next && bus.req1_valid;
  assign bus.txd_data   = txd_q;
  assign bus.valid      = valid_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.abort      = abort_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    to_d         = to_q;
    end_d        = end_q;
    txd_d        = txd_q;
    valid_d      = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          grant_d      = pick;
          last_grant_d = pick[REQ1];
          to_d         = '0;
          end_d        = 1'b0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          txd_d   = sel_data;
          valid_d = 1'b1;
          end_d   = sel_last;
          to_d    = '0;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else if (!sel_valid) begin
          if (to_q == TO_LAST) begin
            // last_grant is left alone so the other source wins next.
            abort_d = 1'b1;
            grant_d = '0;
            to_d    = '0;
            state_d = ST_IDLE;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else begin
          // Source is presenting data; only the transmitter is stalling.
          to_d = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (end_q) begin
            end_d   = 1'b0;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= 1'(REQ1);
      hold_q       <= '0;
      to_q         <= '0;
      end_q        <= 1'b0;
      txd_q        <= '0;
      valid_q      <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      to_q         <= to_d;
      end_q        <= end_d;
      txd_q        <= txd_d;
      valid_q      <= valid_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_par8_tx_arbiter.sv
// Self-checking bench for par8_tx_arbiter: byte sources fed from queues,
// expected bytes scoreboarded in issue order, plus a simple transmitter model
// on a 10 MHz bus clock for the long-message check.
module tb_par8_tx_arbiter;
  import par8_tx_arbiter_pkg::*;

  localparam int unsigned HOLDOFF = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TO_W    = 5;

  logic clk = 1'b0;
  logic bus_clk = 1'b0;
  logic reset = 1'b1;
  always #5  clk = ~clk;
  always #50 bus_clk = ~bus_clk;

  par8_tx_arbiter_if bus ();

  par8_tx_arbiter #(
    .HOLDOFF (HOLDOFF),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] exp_q[$];
  bit         src_en0 = 1'b0;
  bit         src_en1 = 1'b0;
  bit         rn_manual = 1'b1;
  bit         harness = 1'b0;
  bit         pend_tog = 1'b0;
  bit         ack_tog = 1'b0;
  logic [7:0] tx_hold;
  logic [7:0] rx_q[$];

  int  cyc = 0;
  int  n_valid = 0;
  int  last_valid_cyc = -1;
  int  abort_cnt = 0;
  int  abort_cyc = 0;
  bit  chk_gap = 1'b0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(int src, int len, logic [7:0] base);
    logic [7:0] d;
    logic       l;
    for (int i = 0; i < len; i++) begin
      d = base + 8'(i);
      l = (i == len - 1);
      if (src == 0) q0.push_back({l, d});
      else          q1.push_back({l, d});
      exp_q.push_back({(src == 0) ? 2'b01 : 2'b10, d});
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((exp_q.size() != 0 || bus.busy) && n < budget);
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, %0d bytes pending", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Source drivers and transmitter ready: a transfer seen at the negedge
  // completes at the next posedge, after which the next byte is presented.
  initial begin : src_drv
    bit f0, f1;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.ready_next = 1'b1;
    forever begin
      @(negedge clk);
      f0 = bus.req0_valid && bus.req0_ready;
      f1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      if (src_en0 && q0.size() > 0) begin
        bus.req0_valid = 1'b1;
        {bus.req0_last, bus.req0_data} = q0[0];
      end else begin
        bus.req0_valid = 1'b0;
      end
      if (src_en1 && q1.size() > 0) begin
        bus.req1_valid = 1'b1;
        {bus.req1_last, bus.req1_data} = q1[0];
      end else begin
        bus.req1_valid = 1'b0;
      end
      bus.ready_next = harness ? (pend_tog == ack_tog) : rn_manual;
    end
  end

  // Output monitor / scoreboard.
  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.abort === 1'b1) begin
        abort_cnt++;
        abort_cyc = cyc;
      end
      if (bus.valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte", bus.txd_data);
        end else begin
          e = exp_q.pop_front();
          check("txd_data", 16'(bus.txd_data), 16'(e[7:0]));
          check("grant_at_byte", 16'(bus.grant), 16'(e[9:8]));
        end
        if (chk_gap && last_valid_cyc >= 0)
          check("byte_gap", 16'(cyc - last_valid_cyc), 16'(HOLDOFF + 1));
        last_valid_cyc = cyc;
        if (harness) begin
          check("tx_overrun", 16'(pend_tog != ack_tog), 16'd0);
          tx_hold  = bus.txd_data;
          pend_tog = ~pend_tog;
        end
      end
    end
  end

  // Transmitter bus side on the slow clock.
  initial begin : tx_bus
    forever begin
      @(posedge bus_clk);
      if (harness && pend_tog != ack_tog) begin
        rx_q.push_back(tx_hold);
        ack_tog = pend_tog;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         src;
    int         len;
    logic [7:0] base;
    logic [1:0] exp_grant;
  } msg_vec_t;

  initial begin : main
    msg_vec_t vecs[4];
    int n0, a0, v55, n;

    vecs[0] = '{src: 0, len: 3, base: 8'h10, exp_grant: 2'b01};
    vecs[1] = '{src: 1, len: 1, base: 8'h7E, exp_grant: 2'b10};
    vecs[2] = '{src: 1, len: 4, base: 8'h20, exp_grant: 2'b10};
    vecs[3] = '{src: 0, len: 1, base: 8'hC3, exp_grant: 2'b01};

    // Reset values.
    repeat (3) tick();
    check("rst_valid", 16'(bus.valid), 16'd0);
    check("rst_grant", 16'(bus.grant), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_abort", 16'(bus.abort), 16'd0);
    check("rst_txd", 16'(bus.txd_data), 16'd0);
    check("rst_ready0", 16'(bus.req0_ready), 16'd0);
    check("rst_ready1", 16'(bus.req1_ready), 16'd0);
    reset = 1'b0;
    tick();

    // Single-source messages with the transmitter always ready.
    src_en0 = 1'b1;
    src_en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_gap = 1'b1;
      last_valid_cyc = -1;
      n0 = n_valid;
      send(vecs[i].src, vecs[i].len, vecs[i].base);
      n = 0;
      while (bus.grant == 2'b00 && n < 20) begin tick(); n++; end
      check("vec_grant", 16'(bus.grant), 16'(vecs[i].exp_grant));
      wait_idle(200);
      check("vec_pulses", 16'(n_valid - n0), 16'(vecs[i].len));
      check("vec_end_grant", 16'(bus.grant), 16'd0);
      check("vec_end_busy", 16'(bus.busy), 16'd0);
    end
    chk_gap = 1'b0;

    // Simultaneous requests straight after reset: source 0 first, twice.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      src_en0 = 1'b0;
      src_en1 = 1'b0;
      tick(); tick();
      send(0, 2, (k == 0) ? 8'hA0 : 8'hC0);
      send(1, 1, (k == 0) ? 8'hB0 : 8'hD0);
      src_en0 = 1'b1;
      src_en1 = 1'b1;
      wait_idle(200);
    end

    // Transmitter stall mid-message.
    n0 = n_valid;
    send(0, 4, 8'h40);
    n = 0;
    while (n_valid == n0 && n < 50) begin tick(); n++; end
    rn_manual = 1'b0;
    n0 = n_valid;
    a0 = abort_cnt;
    repeat (50) tick();
    check("stall_no_pulse", 16'(n_valid - n0), 16'd0);
    check("stall_no_abort", 16'(abort_cnt - a0), 16'd0);
    check("stall_busy", 16'(bus.busy), 16'd1);
    rn_manual = 1'b1;
    wait_idle(200);
    check("stall_resume", 16'(n_valid - n0), 16'd3);

    // Source stall timeout; source 0 waits behind the stalled message.
    a0 = abort_cnt;
    q1.push_back({1'b0, 8'h55});
    exp_q.push_back({2'b10, 8'h55});
    n = 0;
    while (bus.grant != 2'b10 && n < 20) begin tick(); n++; end
    send(0, 2, 8'h60);
    n = 0;
    while (abort_cnt == a0 && n < 100) begin tick(); n++; end
    v55 = last_valid_cyc;
    check("abort_seen", 16'(abort_cnt - a0), 16'd1);
    check("abort_delay", 16'(abort_cyc - v55), 16'(HOLDOFF + TIMEOUT));
    check("abort_grant", 16'(bus.grant), 16'd0);
    check("abort_busy", 16'(bus.busy), 16'd0);
    tick();
    check("abort_one_cycle", 16'(bus.abort), 16'd0);
    check("after_abort_grant", 16'(bus.grant), 16'b01);
    wait_idle(200);
    check("abort_once", 16'(abort_cnt - a0), 16'd1);

    // Reset during HOLD after byte 2 of 4.
    n0 = n_valid;
    send(0, 4, 8'h80);
    n = 0;
    while (n_valid < n0 + 2 && n < 100) begin tick(); n++; end
    reset = 1'b1;
    q0.delete();
    exp_q.delete();
    tick();
    check("mid_rst_valid", 16'(bus.valid), 16'd0);
    check("mid_rst_grant", 16'(bus.grant), 16'd0);
    check("mid_rst_busy", 16'(bus.busy), 16'd0);
    check("mid_rst_ready0", 16'(bus.req0_ready), 16'd0);
    reset = 1'b0;
    tick();
    chk_gap = 1'b1;
    last_valid_cyc = -1;
    n0 = n_valid;
    send(0, 4, 8'h90);
    wait_idle(200);
    check("post_rst_pulses", 16'(n_valid - n0), 16'd4);
    chk_gap = 1'b0;

    // Long message through the transmitter model on the bus clock.
    harness = 1'b1;
    tick(); tick();
    send(0, 256, 8'h00);
    wait_idle(20000);
    n = 0;
    while (pend_tog != ack_tog && n < 50) begin tick(); n++; end
    check("rx_count", 16'(rx_q.size()), 16'd256);
    for (int i = 0; i < rx_q.size() && i < 256; i++)
      check("rx_byte", 16'(rx_q[i]), 16'(i));
    harness = 1'b0;

    check("abort_total", 16'(abort_cnt), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
